// File: rtl/mem_block_mover_pkg.sv
// mem_block_mover_pkg
//   Shared definitions for the block mover: operation codes, FSM state
//   encoding and element stride helper.
package mem_block_mover_pkg;

    typedef enum logic [1:0] {
        OP_COPY  = 2'b00,
        OP_FILL  = 2'b01,
        OP_CHECK = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam logic [1:0] STRIDE_BYTE = 2'd1;
    localparam logic [1:0] STRIDE_WORD = 2'd2;

    // Address increment per element for the given element size.
    function automatic logic [1:0] stride_of(input logic byte_mode);
        return byte_mode ? STRIDE_BYTE : STRIDE_WORD;
    endfunction

endpackage

// File: rtl/mem_block_mover.sv
// mem_block_mover
//   DMA-style initiator for a byte-addressed memory port with combinational
//   read and posedge write. Performs COPY, FILL and CHECK over the address
//   space in byte or 16-bit word elements; pointers wrap modulo 2**ADDR_W.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, op, byte_mode  request and its operation / element size
//   src, dst, len, pattern  request operands (latched on accept)
//   busy, done            status: busy outside IDLE, done pulses one cycle
//   err, err_addr         CHECK mismatch / reserved op flag and its address
//   mem_addr, mem_wr_data, mem_we, mem_byte_m   memory request outputs
//   mem_rd_data           memory read data (byte reads sign-extended)
module mem_block_mover
    import mem_block_mover_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              byte_mode,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] pattern,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_we,
    output logic              mem_byte_m,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic              byte_mode_q, byte_mode_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic [DATA_W-1:0] pat_q, pat_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    logic [ADDR_W-1:0] stride;
    logic              mismatch;
    logic              last_elem;
    logic [DATA_W-1:0] wr_word;

    assign stride    = ADDR_W'(stride_of(byte_mode_q));
    assign last_elem = (remain_q == LEN_ONE);
    // Byte reads come back sign-extended, so only the low byte is meaningful.
    assign mismatch  = byte_mode_q ? (mem_rd_data[7:0] != pat_q[7:0])
                                   : (mem_rd_data != pat_q);

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        byte_mode_d = byte_mode_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remain_d    = remain_q;
        pat_d       = pat_q;
        buf_d       = buf_q;
        err_d       = err_q;
        err_addr_d  = err_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d        = op_e'(op);
                    byte_mode_d = byte_mode;
                    src_ptr_d   = src;
                    dst_ptr_d   = dst;
                    remain_d    = len;
                    pat_d       = pattern;
                    err_d       = 1'b0;
                    // Reserved op is flagged even with len==0.
                    if (op_e'(op) == OP_RSVD) begin
                        err_d      = 1'b1;
                        err_addr_d = src;
                        state_d    = ST_DONE;
                    end else if (len == '0) begin
                        state_d = ST_DONE;
                    end else if (op_e'(op) == OP_FILL) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end

            ST_RD: begin
                if (op_q == OP_COPY) begin
                    buf_d   = mem_rd_data;
                    state_d = ST_WR;
                end else if (mismatch) begin
                    // CHECK stops at the first mismatch.
                    err_d      = 1'b1;
                    err_addr_d = src_ptr_q;
                    state_d    = ST_DONE;
                end else begin
                    src_ptr_d = src_ptr_q + stride;
                    remain_d  = remain_q - LEN_ONE;
                    state_d   = last_elem ? ST_DONE : ST_RD;
                end
            end

            ST_WR: begin
                dst_ptr_d = dst_ptr_q + stride;
                if (op_q == OP_COPY) begin
                    src_ptr_d = src_ptr_q + stride;
                end
                remain_d = remain_q - LEN_ONE;
                if (last_elem) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = (op_q == OP_COPY) ? ST_RD : ST_WR;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_COPY;
            byte_mode_q <= 1'b0;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remain_q    <= '0;
            pat_q       <= '0;
            buf_q       <= '0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            byte_mode_q <= byte_mode_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remain_q    <= remain_d;
            pat_q       <= pat_d;
            buf_q       <= buf_d;
            err_q       <= err_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Port decode: from registered state only, so an async reset drops
    // mem_we and busy without waiting for a clock edge.
    // ------------------------------------------------------------------
    assign wr_word = (op_q == OP_COPY) ? buf_q : pat_q;

    always_comb begin
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_we      = 1'b0;
        mem_byte_m  = 1'b0;
        case (state_q)
            ST_RD: begin
                mem_addr   = src_ptr_q;
                mem_byte_m = byte_mode_q;
            end
            ST_WR: begin
                mem_addr    = dst_ptr_q;
                mem_we      = 1'b1;
                mem_byte_m  = byte_mode_q;
                mem_wr_data = byte_mode_q ? {{(DATA_W-8){1'b0}}, wr_word[7:0]}
                                          : wr_word;
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign err      = err_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mem_block_mover.sv
// tb_mem_block_mover
//   Directed bench for mem_block_mover with a byte-addressed memory model on
//   the mem_* port. Expected completions go into a queue at issue time; a
//   monitor pops one on every done pulse and checks latency, err, err_addr
//   and write count. Memory contents are checked after each transfer.
module tb_mem_block_mover;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 16;

    logic              clk, rst_n;
    logic              start, byte_mode;
    logic [1:0]        op;
    logic [ADDR_W-1:0] src, dst;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] pattern;
    logic              busy, done, err;
    logic [ADDR_W-1:0] err_addr, mem_addr;
    logic [DATA_W-1:0] mem_wr_data, mem_rd_data;
    logic              mem_we, mem_byte_m;

    mem_block_mover #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .byte_mode(byte_mode),
        .src(src), .dst(dst), .len(len), .pattern(pattern),
        .busy(busy), .done(done), .err(err), .err_addr(err_addr),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_we(mem_we),
        .mem_byte_m(mem_byte_m), .mem_rd_data(mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- byte-addressed memory model ----------------
    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] mem_a1;
    logic              bd_we;
    logic [ADDR_W-1:0] bd_addr;
    logic [7:0]        bd_data;

    assign mem_a1 = mem_addr + ADDR_W'(1);
    always_comb begin
        if (mem_byte_m) mem_rd_data = {{8{mem[mem_addr][7]}}, mem[mem_addr]};
        else            mem_rd_data = {mem[mem_a1], mem[mem_addr]};
    end

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (mem_we) begin
            mem[mem_addr] <= mem_wr_data[7:0];
            if (!mem_byte_m) mem[mem_a1] <= mem_wr_data[15:8];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        string             name;
        int                cycles;
        logic              err;
        logic [ADDR_W-1:0] err_addr;
        int                wes;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts cycles from the accepting edge and write pulses,
    // compares against the head of the queue on each done pulse.
    bit mon_active = 0;
    int mon_cyc = 0;
    int mon_we  = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 0;
        end else begin
            if (mon_active) begin
                mon_cyc++;
                if (mem_we) mon_we++;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk({e.name, "_latency"}, mon_cyc, e.cycles);
                        chk({e.name, "_err"}, {31'd0, err}, {31'd0, e.err});
                        if (e.err) chk({e.name, "_err_addr"}, {12'd0, err_addr}, {12'd0, e.err_addr});
                        chk({e.name, "_we_count"}, mon_we, e.wes);
                    end
                    mon_active = 0;
                end
            end else if (done) begin
                chk("done_without_start", 32'd1, 32'd0);
            end
            if (start && !busy) begin
                mon_active = 1;
                mon_cyc    = 0;
                mon_we     = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic set_req(input logic [1:0] o, input logic bm, input logic [ADDR_W-1:0] s,
                           input logic [ADDR_W-1:0] d, input logic [LEN_W-1:0] n,
                           input logic [DATA_W-1:0] p);
        op = o; byte_mode = bm; src = s; dst = d; len = n; pattern = p;
    endtask

    // Called #1 after a posedge with the DUT idle; start is seen at the next edge.
    task automatic issue(input string name, input logic [1:0] o, input logic bm,
                         input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                         input logic [LEN_W-1:0] n, input logic [DATA_W-1:0] p,
                         input int cyc, input logic e, input logic [ADDR_W-1:0] ea, input int wes);
        exp_t x;
        x.name = name; x.cycles = cyc; x.err = e; x.err_addr = ea; x.wes = wes;
        exp_q.push_back(x);
        set_req(o, bm, s, d, n, p);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        if (k == 200) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (k == 200) chk({name, "_done_timeout"}, 32'd1, 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        set_req(2'b00, 1'b0, '0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_byte_m", {31'd0, mem_byte_m}, 32'd0);
        chk("rst_err_addr", {12'd0, err_addr}, 32'd0);
        chk("rst_mem_addr", {12'd0, mem_addr}, 32'd0);
        chk("rst_wr_data", {16'd0, mem_wr_data}, 32'd0);

        // Preload (DUT held in reset, no writes from it).
        for (int i = 0; i < 6; i++) poke(ADDR_W'(32'h100 + i), 8'(8'h11 * (i + 1)));
        poke(20'h00002, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            poke(ADDR_W'(32'h1000 + 2*i), (i == 2) ? 8'h35 : 8'h34);
            poke(ADDR_W'(32'h1001 + 2*i), 8'h12);
        end
        poke(20'h02000, 8'h80); poke(20'h02001, 8'h80);
        poke(20'h04000, 8'hC3);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: COPY word, 3 elements, 2N+1 latency.
        issue("copy_word", 2'b00, 1'b0, 20'h00100, 20'h00200, 16'd3, 16'h0, 7, 1'b0, '0, 3);
        wait_idle("copy_word");
        for (int i = 0; i < 6; i++)
            chk($sformatf("copy_byte%0d", i), {24'd0, mem[ADDR_W'(32'h200 + i)]}, 32'(8'h11 * (i + 1)));

        // 2: FILL byte across the top of the address space.
        issue("fill_wrap", 2'b01, 1'b1, '0, 20'hFFFFE, 16'd4, 16'h00A5, 5, 1'b0, '0, 4);
        wait_idle("fill_wrap");
        chk("fill_FFFFE", {24'd0, mem[20'hFFFFE]}, 32'hA5);
        chk("fill_FFFFF", {24'd0, mem[20'hFFFFF]}, 32'hA5);
        chk("fill_00000", {24'd0, mem[20'h00000]}, 32'hA5);
        chk("fill_00001", {24'd0, mem[20'h00001]}, 32'hA5);
        chk("fill_00002_untouched", {24'd0, mem[20'h00002]}, 32'h5A);

        // 3: CHECK word, mismatch on the 3rd element.
        issue("check_mis", 2'b10, 1'b0, 20'h01000, '0, 16'd5, 16'h1234, 4, 1'b1, 20'h01004, 0);
        wait_idle("check_mis");

        // 4: len=0, then reserved op; err must persist while idle.
        issue("len0", 2'b00, 1'b0, 20'h00100, 20'h00300, 16'd0, 16'h0, 1, 1'b0, '0, 0);
        wait_idle("len0");
        issue("rsvd", 2'b11, 1'b0, 20'h12345, 20'h00300, 16'd5, 16'h0, 1, 1'b1, 20'h12345, 0);
        wait_idle("rsvd");
        repeat (3) @(posedge clk);
        #1;
        chk("err_held", {31'd0, err}, 32'd1);
        chk("err_addr_held", {12'd0, err_addr}, 32'h12345);

        // Byte CHECK of 0x80: sign-extended read must still match low byte.
        issue("check_byte", 2'b10, 1'b1, 20'h02000, '0, 16'd2, 16'h0080, 3, 1'b0, '0, 0);
        wait_idle("check_byte");

        // 5: reset during COPY write phase.
        issue("aborted", 2'b00, 1'b0, 20'h00100, 20'h05000, 16'd3, 16'h0, 7, 1'b0, '0, 3);
        begin
            int k;
            for (k = 0; k < 50; k++) begin
                @(negedge clk);
                if (mem_we) break;
            end
            if (k == 50) chk("abort_wait_we", 32'd1, 32'd0);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("abort_we", {31'd0, mem_we}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue("fill_after_rst", 2'b01, 1'b0, '0, 20'h06000, 16'd1, 16'h7777, 2, 1'b0, '0, 1);
        wait_idle("fill_after_rst");
        chk("fill_after_rst_word", {16'd0, mem[20'h06001], mem[20'h06000]}, 32'h7777);

        // 6: start while busy is ignored; start in the IDLE cycle after done is taken.
        issue("fill_busy", 2'b01, 1'b0, '0, 20'h03000, 16'd3, 16'hBEEF, 4, 1'b0, '0, 3);
        set_req(2'b00, 1'b0, 20'h00100, 20'h04000, 16'd1, 16'h0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("fill_busy");
        begin
            exp_t x;
            x.name = "copy_back2back"; x.cycles = 5; x.err = 1'b0; x.err_addr = '0; x.wes = 2;
            exp_q.push_back(x);
        end
        set_req(2'b00, 1'b1, 20'h06000, 20'h06100, 16'd2, 16'h0);
        start = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("copy_back2back");
        chk("busy_start_ignored", {24'd0, mem[20'h04000]}, 32'hC3);
        chk("fill_busy_word2", {16'd0, mem[20'h03005], mem[20'h03004]}, 32'hBEEF);
        chk("b2b_byte0", {24'd0, mem[20'h06100]}, 32'h77);
        chk("b2b_byte1", {24'd0, mem[20'h06101]}, 32'h77);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
